// File: rtl/leiwand_rv32_uart_tx_if.sv
// Core memory bus as seen by a peripheral slave: valid/ready handshake with
// byte write enables (wen == 0 is a read).
interface leiwand_rv32_uart_tx_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wen, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wen, addr, wdata, output ready, rdata);
endinterface

// File: rtl/leiwand_rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO fed by bus writes, drained by a
// baud-rate state machine. Registers: TXDATA, STATUS, DIVISOR.
module leiwand_rv32_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                  clk,
  input  logic                  reset,
  leiwand_rv32_uart_tx_if.slave bus,
  output logic                  tx,
  output logic                  irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic        ovf_q;
  logic [15:0] divisor_q;
  logic [15:0] div_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        irq_q;

  logic        sel, acc, full, empty, busy;
  logic        push_req, push, pop, ovf_clr, baud_end;
  logic [1:0]  off;
  logic [15:0] div_eff;
  logic [31:0] rd_val;

  assign sel      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign acc      = bus.valid && sel && !ready_q;
  assign off      = bus.addr[3:2];
  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign busy     = (state_q != IDLE);
  assign push_req = acc && (off == 2'd0) && bus.wen[0];
  // Full is judged before any same-cycle pop, so a write into a full FIFO drops.
  assign push     = push_req && !full;
  assign ovf_clr  = acc && (off == 2'd1) && bus.wen[0] && bus.wdata[3];
  assign baud_end = (baud_q == div_q - 16'd1);
  assign pop      = !empty && ((state_q == IDLE) || (state_q == STOP && baud_end));
  assign div_eff  = (divisor_q == 16'd0) ? 16'd1 : divisor_q;

  always_comb begin
    rd_val = '0;
    case (off)
      2'd1:    rd_val = {16'h0, 8'(cnt_q), 4'h0, ovf_q, busy, empty, full};
      2'd2:    rd_val = {16'h0, divisor_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      divisor_q <= DEFAULT_DIV;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      ready_q <= acc;
      if (acc) rdata_q <= rd_val;
      if (push_req && full) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
      if (acc && off == 2'd2) begin
        if (bus.wen[0]) divisor_q[7:0]  <= bus.wdata[7:0];
        if (bus.wen[1]) divisor_q[15:8] <= bus.wdata[15:8];
      end
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      div_q   <= 16'd1;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      irq_q <= empty && !busy;
      if (pop) begin
        // Same load from IDLE and from the last stop-bit cycle: no idle gap.
        shift_q <= fifo_q[rd_q];
        div_q   <= div_eff;
        baud_q  <= '0;
        bit_q   <= '0;
        tx_q    <= 1'b0;
        state_q <= START;
      end else begin
        case (state_q)
          IDLE: tx_q <= 1'b1;
          START: begin
            if (baud_end) begin
              baud_q  <= '0;
              tx_q    <= shift_q[0];
              state_q <= DATA;
            end else baud_q <= baud_q + 16'd1;
          end
          DATA: begin
            if (baud_end) begin
              baud_q <= '0;
              if (bit_q == 3'd7) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                bit_q   <= bit_q + 3'd1;
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
              end
            end else baud_q <= baud_q + 16'd1;
          end
          STOP: begin
            if (baud_end) begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end else baud_q <= baud_q + 16'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign tx        = tx_q;
  assign irq_empty = irq_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.addr[1:0], bus.wdata[31:16], bus.wen[3:2]};

endmodule
